// File: rtl/patbuf_pkg.sv
// Shared types and default widths for the pattern buffer write-port arbiter,
// the PAT core and the pattern buffer.
package patbuf_pkg;

  localparam int D_WIDTH      = 8;
  localparam int BUFP_WIDTH   = 3;
  localparam int FIELDP_WIDTH = 5;
  localparam int STARVE_WIDTH = 4;
  localparam int STARVE_LIMIT = 15;
  localparam int STALL_CNT_W  = 16;

  typedef enum logic [1:0] {
    S_PAT   = 2'd0,
    S_HOST  = 2'd1,
    S_DRAIN = 2'd2
  } arb_state_t;

  typedef logic [BUFP_WIDTH-1:0]   bufp_t;
  typedef logic [FIELDP_WIDTH-1:0] fieldp_t;

  typedef struct packed {
    bufp_t   bufp;
    fieldp_t fieldp;
  } buf_addr_t;

endpackage

// File: rtl/patbuf_starve_ctr.sv
// Saturating host wait counter; limit_hit forces a host grant over PAT.
module patbuf_starve_ctr #(
  parameter int W     = 4,
  parameter int LIMIT = 15
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         inc,
  input  logic         clr,
  output logic [W-1:0] cnt,
  output logic         limit_hit
);

  localparam logic [W-1:0] CNT_MAX = '1;
  localparam logic [W-1:0] CNT_LIM = W'(LIMIT);

  always_ff @(posedge clk or posedge reset) begin
    if (reset)                       cnt <= '0;
    else if (clr)                    cnt <= '0;
    else if (inc && cnt != CNT_MAX)  cnt <= cnt + W'(1);
  end

  assign limit_hit = (cnt == CNT_LIM);

endmodule

// File: rtl/patbuf_arbiter.sv
// Pattern buffer write-port arbiter: PAT has priority, host bursts are starvation-protected.
// Optional stall statistics counter enabled by PATBUF_ARB_STATS_EN.
module patbuf_arbiter
  import patbuf_pkg::*;
#(
  parameter int d_width      = D_WIDTH,
  parameter int bufp_width   = BUFP_WIDTH,
  parameter int fieldp_width = FIELDP_WIDTH,
  parameter int starve_limit = STARVE_LIMIT,
  parameter int starve_width = STARVE_WIDTH
) (
  input  logic                               clk,
  input  logic                               reset,
  input  logic                               pat_active,
  input  logic [bufp_width-1:0]              pat_bufp,
  input  logic [fieldp_width-1:0]            pat_fieldp,
  input  logic [fieldp_width-1:0]            pat_fieldwp,
  input  logic                               pat_write_en,
  input  logic [d_width-1:0]                 pat_field_in,
  output logic                               pat_stall,
  input  logic                               host_req,
  input  logic [bufp_width+fieldp_width-1:0] host_adr,
  input  logic [fieldp_width-1:0]            host_len,
  input  logic [d_width-1:0]                 host_wdata,
  input  logic                               host_wvalid,
  output logic                               host_wready,
  output logic                               host_done,
  output logic [bufp_width+fieldp_width-1:0] buf_fieldp,
  output logic [bufp_width+fieldp_width-1:0] buf_fieldwp,
  output logic                               field_write_en,
  output logic [d_width-1:0]                 field_in,
  output logic [15:0]                        stall_count
);

  typedef struct packed {
    logic [bufp_width-1:0]   bufp;
    logic [fieldp_width-1:0] fieldp;
    logic [fieldp_width-1:0] left;
  } burst_t;

  arb_state_t              state, state_nx;
  burst_t                  burst_q;
  logic                    grant, accept, last_beat;
  logic                    starve_inc, limit_hit;
  logic [starve_width-1:0] starve_cnt;

  assign grant      = (state == S_PAT) & host_req & (~pat_active | limit_hit);
  assign starve_inc = (state == S_PAT) & host_req & ~grant;
  assign accept     = (state == S_HOST) & host_wvalid;
  assign last_beat  = accept & (burst_q.left == '0);

  patbuf_starve_ctr #(
    .W     (starve_width),
    .LIMIT (starve_limit)
  ) u_starve (
    .clk       (clk),
    .reset     (reset),
    .inc       (starve_inc),
    .clr       (grant),
    .cnt       (starve_cnt),
    .limit_hit (limit_hit)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= S_PAT;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      S_PAT:   if (grant) state_nx = S_HOST;
      S_HOST:  if (last_beat) state_nx = S_DRAIN;
      S_DRAIN: state_nx = S_PAT;
      default: state_nx = S_PAT;
    endcase
  end

  // Burst pointer wraps inside its buffer: only the field part advances.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      burst_q <= '0;
    end else if (grant) begin
      burst_q.bufp   <= host_adr[bufp_width+fieldp_width-1:fieldp_width];
      burst_q.fieldp <= host_adr[fieldp_width-1:0];
      burst_q.left   <= host_len;
    end else if (accept) begin
      burst_q.fieldp <= burst_q.fieldp + fieldp_width'(1);
      if (!last_beat) burst_q.left <= burst_q.left - fieldp_width'(1);
    end
  end

  assign buf_fieldp = {pat_bufp, pat_fieldp};
  assign host_done  = (state == S_DRAIN);

  always_comb begin
    field_write_en = pat_write_en;
    buf_fieldwp    = {pat_bufp, pat_fieldwp};
    field_in       = pat_field_in;
    pat_stall      = 1'b0;
    host_wready    = 1'b0;
    if (state == S_HOST) begin
      field_write_en = host_wvalid;
      buf_fieldwp    = {burst_q.bufp, burst_q.fieldp};
      field_in       = host_wdata;
      pat_stall      = pat_active;
      host_wready    = 1'b1;
    end
  end

`ifdef PATBUF_ARB_STATS_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset)                                  stall_count <= '0;
    else if (pat_stall && stall_count != 16'hFFFF) stall_count <= stall_count + 16'd1;
  end
`else
  assign stall_count = 16'h0000;
`endif

  logic unused_ok;
  assign unused_ok = ^starve_cnt;

endmodule

// File: tb/tb_patbuf_arbiter.sv
// Randomized and directed bench for patbuf_arbiter against a cycle-level behavioural model.
module tb_patbuf_arbiter;

  logic       clk = 1'b0;
  logic       reset;
  logic       pat_active;
  logic [2:0] pat_bufp;
  logic [4:0] pat_fieldp, pat_fieldwp;
  logic       pat_write_en;
  logic [7:0] pat_field_in;
  logic       pat_stall;
  logic       host_req;
  logic [7:0] host_adr;
  logic [4:0] host_len;
  logic [7:0] host_wdata;
  logic       host_wvalid;
  logic       host_wready, host_done;
  logic [7:0] buf_fieldp, buf_fieldwp;
  logic       field_write_en;
  logic [7:0] field_in;
  logic [15:0] stall_count;

  always #5 clk = ~clk;

  patbuf_arbiter dut (
    .clk(clk), .reset(reset),
    .pat_active(pat_active), .pat_bufp(pat_bufp), .pat_fieldp(pat_fieldp),
    .pat_fieldwp(pat_fieldwp), .pat_write_en(pat_write_en), .pat_field_in(pat_field_in),
    .pat_stall(pat_stall),
    .host_req(host_req), .host_adr(host_adr), .host_len(host_len),
    .host_wdata(host_wdata), .host_wvalid(host_wvalid),
    .host_wready(host_wready), .host_done(host_done),
    .buf_fieldp(buf_fieldp), .buf_fieldwp(buf_fieldwp),
    .field_write_en(field_write_en), .field_in(field_in),
    .stall_count(stall_count)
  );

  int n_chk = 0, n_fail = 0;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  // Model: mode 0 = PAT owns port, 1 = host burst, 2 = one-cycle gap after a burst.
  int m_mode, m_wait, m_addr, m_left, m_stalls;
  int cyc_n = 0, gnt_cyc = -1, done_cyc = -1;
  logic drain_we, drain_stall;
  int hw_q[$];

  task automatic model_rst();
    m_mode = 0; m_wait = 0; m_addr = 0; m_left = 0; m_stalls = 0;
  endtask

  task automatic cyc();
    logic       e_we, e_stall, e_rdy, e_done;
    logic [7:0] e_wp, e_din;
    int         e_sc;
    @(negedge clk);
    if (reset) model_rst();
    if (m_mode == 1) begin
      e_we = host_wvalid; e_wp = m_addr[7:0]; e_din = host_wdata;
      e_stall = pat_active; e_rdy = 1'b1; e_done = 1'b0;
    end else begin
      e_we = pat_write_en; e_wp = {pat_bufp, pat_fieldwp}; e_din = pat_field_in;
      e_stall = 1'b0; e_rdy = 1'b0; e_done = (m_mode == 2);
    end
`ifdef PATBUF_ARB_STATS_EN
    e_sc = m_stalls;
`else
    e_sc = 0;
`endif
    chk("buf_fieldp", buf_fieldp, {pat_bufp, pat_fieldp});
    chk("field_write_en", field_write_en, e_we);
    chk("buf_fieldwp", buf_fieldwp, e_wp);
    chk("field_in", field_in, e_din);
    chk("pat_stall", pat_stall, e_stall);
    chk("host_wready", host_wready, e_rdy);
    chk("host_done", host_done, e_done);
    chk("stall_count", stall_count, e_sc);
    if (field_write_en && host_wready) hw_q.push_back(int'(buf_fieldwp));
    if (host_done) begin
      done_cyc = cyc_n; drain_we = field_write_en; drain_stall = pat_stall;
    end
    if (!reset) begin
      if (e_stall && m_stalls < 65535) m_stalls++;
      case (m_mode)
        0: if (host_req && (!pat_active || m_wait == 15)) begin
             m_mode = 1; m_addr = int'(host_adr); m_left = int'(host_len);
             m_wait = 0; gnt_cyc = cyc_n;
           end else if (host_req && m_wait < 15) m_wait++;
        1: if (host_wvalid) begin
             m_addr = (m_addr & 'hE0) | ((m_addr + 1) & 'h1F);
             if (m_left == 0) m_mode = 2; else m_left--;
           end
        default: m_mode = 0;
      endcase
    end
    cyc_n++;
    @(posedge clk); #1;
  endtask

  task automatic burst(input logic [7:0] adr, input logic [4:0] len, input logic pa,
                       input bit gaps, input bit keep_req, output int waited);
    int t0, guard;
    t0 = cyc_n; hw_q.delete(); done_cyc = -1;
    host_adr = adr; host_len = len; host_req = 1'b1; pat_active = pa; host_wvalid = 1'b0;
    guard = 0;
    while (m_mode != 1 && guard < 40) begin cyc(); guard++; end
    chk("grant_seen", host_wready, 1'b1);
    waited = gnt_cyc - t0;
    host_req = keep_req; host_adr = 8'($urandom); host_len = 5'($urandom);
    guard = 0;
    while (done_cyc < 0 && guard < 80) begin
      host_wvalid = gaps ? 1'($urandom_range(0, 1)) : 1'b1;
      host_wdata  = 8'($urandom);
      cyc(); guard++;
    end
    host_wvalid = 1'b0;
    chk("done_seen", done_cyc >= 0, 1'b1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int w;
    reset = 1'b1; pat_active = 0; pat_bufp = 0; pat_fieldp = 0; pat_fieldwp = 0;
    pat_write_en = 0; pat_field_in = 0; host_req = 0; host_adr = 0; host_len = 0;
    host_wdata = 0; host_wvalid = 0;
    model_rst();
    #1;
    chk("rst_wready", host_wready, 1'b0);
    chk("rst_done", host_done, 1'b0);
    chk("rst_we", field_write_en, 1'b0);
    chk("rst_stall_cnt", stall_count, 16'h0);
    cyc(); cyc();
    reset = 1'b0;
    cyc();

    // Plain burst, PAT idle
    burst(8'h23, 5'd3, 1'b0, 1'b0, 1'b0, w);
    chk("b1_beats", hw_q.size(), 4);
    for (int i = 0; i < 4 && i < hw_q.size(); i++) chk("b1_addr", hw_q[i], 8'h23 + i);
    chk("b1_done_lat", done_cyc - gnt_cyc, 5);
    cyc();

    // Field wrap keeps bufp
    burst(8'h3E, 5'd2, 1'b0, 1'b0, 1'b0, w);
    chk("b2_beats", hw_q.size(), 3);
    if (hw_q.size() == 3) begin
      chk("b2_a0", hw_q[0], 8'h3E);
      chk("b2_a1", hw_q[1], 8'h3F);
      chk("b2_a2", hw_q[2], 8'h20);
    end
    cyc();

    // Starvation: PAT always active
    pat_write_en = 1'b1; pat_field_in = 8'hA5; pat_bufp = 3'd5; pat_fieldwp = 5'd7;
    burst(8'h51, 5'd1, 1'b1, 1'b0, 1'b0, w);
    chk("starve_wait", w, 15);
    chk("b3_beats", hw_q.size(), 2);
    pat_write_en = 1'b0;
    cyc();

    // Valid gaps mid-burst
    burst(8'h60, 5'd3, 1'b0, 1'b1, 1'b0, w);
    chk("b4_beats", hw_q.size(), 4);
    cyc();

    // Back-to-back requests with PAT active: drain cycle lets PAT write
    pat_write_en = 1'b1; pat_field_in = 8'h5A;
    burst(8'h10, 5'd1, 1'b1, 1'b0, 1'b1, w);
    chk("b2b_drain_we", drain_we, 1'b1);
    chk("b2b_drain_stall", drain_stall, 1'b0);
    cyc(); cyc();
    chk("b2b_no_regrant", host_wready, 1'b0);
    host_req = 1'b0; pat_write_en = 1'b0; pat_active = 1'b0;
    cyc();

    // Reset during beat 2
    done_cyc = -1;
    host_req = 1'b1; host_adr = 8'h44; host_len = 5'd3;
    for (int g = 0; g < 5 && m_mode != 1; g++) cyc();
    host_req = 1'b0; host_wvalid = 1'b1; host_wdata = 8'h11;
    cyc();
    reset = 1'b1; host_wdata = 8'h22;
    #1;
    chk("mid_rst_we", field_write_en, 1'b0);
    chk("mid_rst_done", host_done, 1'b0);
    chk("mid_rst_stall_cnt", stall_count, 16'h0);
    cyc();
    reset = 1'b0;
    for (int i = 0; i < 6; i++) cyc();
    host_wvalid = 1'b0;
    chk("mid_rst_no_done", done_cyc < 0, 1'b1);

    // Randomized traffic
    for (int i = 0; i < 2500; i++) begin
      host_req     = ($urandom_range(0, 3) != 0);
      pat_active   = 1'($urandom_range(0, 9) < 7);
      pat_bufp     = 3'($urandom); pat_fieldp = 5'($urandom); pat_fieldwp = 5'($urandom);
      pat_write_en = 1'($urandom); pat_field_in = 8'($urandom);
      host_adr     = 8'($urandom); host_len = 5'($urandom_range(0, 6));
      host_wdata   = 8'($urandom); host_wvalid = 1'($urandom_range(0, 3) != 0);
      reset        = ($urandom_range(0, 499) == 0);
      cyc();
    end
    reset = 1'b0;
    cyc();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
